pc_sequencer: RTL and testbench

Fetch-stage program-counter sequencer. It sits directly upstream of the instruction memory and drives its program_counter and program_increment inputs. It advances the PC one word per cycle and handles taken branches, pipeline stalls, halt/resume, and the ARMv4 "PC reads as current+8" value. The PC is word-indexed, 8 bits.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/pc_sequencer_if.sv | 55 +++++
 rtl/pc_sequencer.sv | 107 ++++++++++
 tb/tb_pc_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: PC width/reset defaults, the ARMv4 PC read offset,
// and the sequencer state encoding.
package cpu_pkg;

  localparam int unsigned ADDR_W_DEFAULT         = 8;
  localparam int unsigned RESET_VECTOR_DEFAULT   = 0;
  localparam int unsigned PC_READ_OFFSET_DEFAULT = 2;

  typedef enum logic [1:0] {
    StBoot  = 2'd0,
    StRun   = 2'd1,
    StStall = 2'd2,
    StHalt  = 2'd3
  } pc_state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-control bundle between the PC sequencer (master) and its environment (slave).
// wrap_fault exists only when PC_WRAP_TRAP_EN is defined.
interface pc_sequencer_if #(
  parameter int unsigned ADDR_W = cpu_pkg::ADDR_W_DEFAULT
);

  logic              stall;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic              halt_req;
  logic              resume;
  logic [ADDR_W-1:0] program_counter;
  logic              program_increment;
  logic [ADDR_W-1:0] pc_read_value;
  logic              flush;
  logic              halted;
`ifdef PC_WRAP_TRAP_EN
  logic              wrap_fault;
`endif

  modport master (
    input  stall,
    input  branch_taken,
    input  branch_target,
    input  halt_req,
    input  resume,
    output program_counter,
    output program_increment,
    output pc_read_value,
    output flush,
    output halted
`ifdef PC_WRAP_TRAP_EN
    ,
    output wrap_fault
`endif
  );

  modport slave (
    output stall,
    output branch_taken,
    output branch_target,
    output halt_req,
    output resume,
    input  program_counter,
    input  program_increment,
    input  pc_read_value,
    input  flush,
    input  halted
`ifdef PC_WRAP_TRAP_EN
    ,
    input  wrap_fault
`endif
  );

endinterface

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: boot, run, stall, halt, branch with decode flush.
// PC_WRAP_TRAP_EN: trap a sequential 2^ADDR_W-1 -> 0 wrap into HALT and raise wrap_fault.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W         = ADDR_W_DEFAULT,
  parameter int unsigned RESET_VECTOR   = RESET_VECTOR_DEFAULT,
  parameter int unsigned PC_READ_OFFSET = PC_READ_OFFSET_DEFAULT
) (
  input logic             clk,
  input logic             reset,
  pc_sequencer_if.master  bus
);

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inc_q, inc_d;
  logic              flush_q, flush_d;
  logic              halted_q, halted_d;
`ifdef PC_WRAP_TRAP_EN
  logic              wrap_fault_q, wrap_fault_d;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    inc_d    = 1'b0;
    flush_d  = 1'b0;
    halted_d = 1'b0;
`ifdef PC_WRAP_TRAP_EN
    wrap_fault_d = wrap_fault_q;
`endif
    unique case (state_q)
      StBoot: begin
        state_d = StRun;
        inc_d   = 1'b1;
      end
      StRun, StStall: begin
        if (bus.halt_req) begin
          state_d  = StHalt;
          halted_d = 1'b1;
        end else if (bus.branch_taken) begin
          state_d = StRun;
          pc_d    = bus.branch_target;
          inc_d   = 1'b1;
          flush_d = 1'b1;
        end else if (bus.stall) begin
          state_d = StStall;
`ifdef PC_WRAP_TRAP_EN
        end else if (pc_q == {ADDR_W{1'b1}}) begin
          // Sequential wrap is trapped; a branch to low memory is not.
          state_d      = StHalt;
          halted_d     = 1'b1;
          wrap_fault_d = 1'b1;
`endif
        end else begin
          state_d = StRun;
          pc_d    = pc_q + 1'b1;
          inc_d   = 1'b1;
        end
      end
      StHalt: begin
        if (bus.resume && !bus.halt_req) begin
          state_d = StRun;
          inc_d   = 1'b1;
        end else begin
          halted_d = 1'b1;
        end
      end
      default: begin
        state_d = StBoot;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StBoot;
      pc_q     <= ADDR_W'(RESET_VECTOR);
      inc_q    <= 1'b0;
      flush_q  <= 1'b0;
      halted_q <= 1'b0;
`ifdef PC_WRAP_TRAP_EN
      wrap_fault_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      inc_q    <= inc_d;
      flush_q  <= flush_d;
      halted_q <= halted_d;
`ifdef PC_WRAP_TRAP_EN
      wrap_fault_q <= wrap_fault_d;
`endif
    end
  end

  assign bus.program_counter   = pc_q;
  assign bus.program_increment = inc_q;
  assign bus.flush             = flush_q;
  assign bus.halted            = halted_q;
  assign bus.pc_read_value     = pc_q + ADDR_W'(PC_READ_OFFSET);
`ifdef PC_WRAP_TRAP_EN
  assign bus.wrap_fault        = wrap_fault_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; expected values are hand-derived per vector.
// Honours PC_WRAP_TRAP_EN to select the wrap expectations.
module tb_pc_sequencer;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  pc_sequencer_if #(.ADDR_W(8)) bus ();

  pc_sequencer #(
    .ADDR_W         (8),
    .RESET_VECTOR   (0),
    .PC_READ_OFFSET (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs set before a step are sampled on its edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 8'h00;
    bus.halt_req      = 1'b0;
    bus.resume        = 1'b0;
  endtask

  task automatic branch_to(input logic [7:0] tgt);
    bus.branch_taken  = 1'b1;
    bus.branch_target = tgt;
    step();
    bus.branch_taken  = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_inputs();
    reset = 1'b1;
    step();
    step();
    check("rst_pc", 32'(bus.program_counter), 32'h0);
    check("rst_inc", 32'(bus.program_increment), 32'h0);
    check("rst_flush", 32'(bus.flush), 32'h0);
    check("rst_halted", 32'(bus.halted), 32'h0);
`ifdef PC_WRAP_TRAP_EN
    check("rst_wrap_fault", 32'(bus.wrap_fault), 32'h0);
`endif
    reset = 1'b0;
    step();  // leave BOOT

    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      check("seq_pc", 32'(bus.program_counter), 32'(i));
      check("seq_inc", 32'(bus.program_increment), 32'h1);
      check("seq_rd", 32'(bus.pc_read_value), 32'(i + 2));
    end
    for (int i = 0; i < 6; i++) step();
    check("run_pc10", 32'(bus.program_counter), 32'd10);

    branch_to(8'h40);
    check("br_pc", 32'(bus.program_counter), 32'h40);
    check("br_flush", 32'(bus.flush), 32'h1);
    check("br_inc", 32'(bus.program_increment), 32'h1);
    step();
    check("br_pc1", 32'(bus.program_counter), 32'h41);
    check("br_flush_off", 32'(bus.flush), 32'h0);
    step();
    check("br_pc2", 32'(bus.program_counter), 32'h42);

    branch_to(8'h07);
    check("st_pre_pc", 32'(bus.program_counter), 32'h07);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("st_pc", 32'(bus.program_counter), 32'h07);
      check("st_inc", 32'(bus.program_increment), 32'h0);
      check("st_flush", 32'(bus.flush), 32'h0);
    end
    bus.stall = 1'b0;
    step();
    check("st_rel_pc", 32'(bus.program_counter), 32'h08);
    check("st_rel_inc", 32'(bus.program_increment), 32'h1);
    bus.stall = 1'b1;
    step();
    check("st2_pc", 32'(bus.program_counter), 32'h08);
    branch_to(8'h20);
    bus.stall = 1'b0;
    check("st_br_pc", 32'(bus.program_counter), 32'h20);
    check("st_br_flush", 32'(bus.flush), 32'h1);
    check("st_br_inc", 32'(bus.program_increment), 32'h1);

    branch_to(8'h30);
    bus.halt_req = 1'b1;
    step();
    bus.halt_req = 1'b0;
    check("h_halted", 32'(bus.halted), 32'h1);
    check("h_pc", 32'(bus.program_counter), 32'h30);
    check("h_inc", 32'(bus.program_increment), 32'h0);
    check("h_rd", 32'(bus.pc_read_value), 32'h32);
    for (int i = 0; i < 10; i++) begin
      bus.branch_taken  = (i % 2) == 0;
      bus.branch_target = 8'h55;
      bus.stall         = (i % 2) == 1;
      step();
      check("h_hold_pc", 32'(bus.program_counter), 32'h30);
      check("h_hold_halted", 32'(bus.halted), 32'h1);
      check("h_hold_flush", 32'(bus.flush), 32'h0);
      check("h_hold_inc", 32'(bus.program_increment), 32'h0);
    end
    clear_inputs();
    bus.halt_req = 1'b1;
    bus.resume   = 1'b1;
    step();
    check("h_both_halted", 32'(bus.halted), 32'h1);
    check("h_both_inc", 32'(bus.program_increment), 32'h0);
    bus.halt_req = 1'b0;
    step();
    bus.resume = 1'b0;
    check("h_res_pc", 32'(bus.program_counter), 32'h30);
    check("h_res_inc", 32'(bus.program_increment), 32'h1);
    check("h_res_halted", 32'(bus.halted), 32'h0);
    step();
    check("h_res_next", 32'(bus.program_counter), 32'h31);

    branch_to(8'hFD);
    step();
    step();
    check("w_pc_ff", 32'(bus.program_counter), 32'hFF);
    check("w_rd_ff", 32'(bus.pc_read_value), 32'h01);
    step();
`ifdef PC_WRAP_TRAP_EN
    check("w_trap_pc", 32'(bus.program_counter), 32'hFF);
    check("w_trap_halted", 32'(bus.halted), 32'h1);
    check("w_trap_fault", 32'(bus.wrap_fault), 32'h1);
    check("w_trap_inc", 32'(bus.program_increment), 32'h0);
    bus.resume = 1'b1;
    step();
    bus.resume = 1'b0;
    check("w_res_fault", 32'(bus.wrap_fault), 32'h1);
    check("w_res_halted", 32'(bus.halted), 32'h0);
    check("w_res_pc", 32'(bus.program_counter), 32'hFF);
`else
    check("w_wrap_pc", 32'(bus.program_counter), 32'h00);
    check("w_wrap_inc", 32'(bus.program_increment), 32'h1);
    check("w_wrap_halted", 32'(bus.halted), 32'h0);
`endif

    bus.halt_req = 1'b1;
    step();
    bus.halt_req = 1'b0;
    check("r_pre_halted", 32'(bus.halted), 32'h1);
    reset             = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 8'h77;
    step();
    check("r_pc", 32'(bus.program_counter), 32'h0);
    check("r_inc", 32'(bus.program_increment), 32'h0);
    check("r_flush", 32'(bus.flush), 32'h0);
    check("r_halted", 32'(bus.halted), 32'h0);
`ifdef PC_WRAP_TRAP_EN
    check("r_wrap_fault", 32'(bus.wrap_fault), 32'h0);
`endif
    reset = 1'b0;
    clear_inputs();
    step();
    check("r_boot_pc", 32'(bus.program_counter), 32'h0);
    check("r_boot_inc", 32'(bus.program_increment), 32'h1);
    check("r_boot_flush", 32'(bus.flush), 32'h0);
    step();
    check("r_run_pc", 32'(bus.program_counter), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
